// File: rtl/nfifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the shared FIFO.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and reports FIFO status (requesters plus FIFO taps).
interface nfifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int GNT_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_last_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     fifo_write_o;
  logic [WIDTH-1:0]         fifo_data_o;
  logic                     fifo_read_i;
  logic                     fifo_empty_i;
  logic [CNT_W-1:0]         occupancy_o;
  logic                     full_o;
  logic [GNT_W-1:0]         grant_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, fifo_read_i, fifo_empty_i,
    output req_ready_o, fifo_write_o, fifo_data_o, occupancy_o, full_o, grant_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, fifo_read_i, fifo_empty_i,
    input  req_ready_o, fifo_write_o, fifo_data_o, occupancy_o, full_o, grant_o
  );

endinterface

// File: rtl/nfifo_wr_arbiter.sv
// Round-robin write arbiter with packet locking in front of a shared nfifo.
// Keeps its own count of reserved/held FIFO entries (the FIFO only exports
// empty) and withholds ready so the FIFO can never overflow. Accepted beats
// reach the FIFO through a one-cycle registered output stage.
module nfifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  nfifo_wr_arbiter_if.slave bus
);

  localparam int GNT_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [GNT_W-1:0] owner_q, owner_d;
  logic [GNT_W-1:0] rrPtr_q, rrPtr_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full_q, full_d;
  logic             write_q, write_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [GNT_W-1:0]   cand;
  logic               hit;
  logic               space;
  logic [NUM_REQ-1:0] readyVec;
  logic               accept;
  logic [WIDTH-1:0]   beatData;
  logic               beatLast;
  logic               dec;

  // Pick the candidate: the lock owner, or the first valid requester after rrPtr.
  always_comb begin
    cand = '0;
    hit  = 1'b0;
    if (state_q == LOCKED) begin
      cand = owner_q;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == GNT_W'(i)) hit = bus.req_valid_i[i];
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hit && bus.req_valid_i[i] && (GNT_W'(i) > rrPtr_q)) begin
          hit  = 1'b1;
          cand = GNT_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hit && bus.req_valid_i[i] && (GNT_W'(i) <= rrPtr_q)) begin
          hit  = 1'b1;
          cand = GNT_W'(i);
        end
      end
    end
  end

  // Ready to the candidate only when a FIFO entry is free and not in reset; mux its beat.
  always_comb begin
    space    = (occ_q < CNT_W'(DEPTH));
    readyVec = '0;
    beatData = '0;
    beatLast = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand == GNT_W'(i)) begin
        readyVec[i] = rstn_i && hit && space;
        beatData    = bus.req_data_i[i*WIDTH +: WIDTH];
        beatLast    = bus.req_last_i[i];
      end
    end
    accept = |readyVec;
  end

  // Next-state for the lock FSM, the output stage and the occupancy counter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rrPtr_d = rrPtr_q;
    grant_d = grant_q;
    write_d = accept;
    data_d  = accept ? beatData : data_q;
    if (accept) begin
      grant_d = cand;
      if (beatLast) begin
        state_d = IDLE;
        rrPtr_d = cand;
      end else begin
        state_d = LOCKED;
        owner_d = cand;
      end
    end
    dec    = bus.fifo_read_i && !bus.fifo_empty_i && (occ_q != '0);
    occ_d  = occ_q + CNT_W'(accept) - CNT_W'(dec);
    full_d = (occ_d == CNT_W'(DEPTH));
  end

  // Register all state and outputs; reset drops any lock and any pending beat.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rrPtr_q <= GNT_W'(NUM_REQ - 1);
      grant_q <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      write_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rrPtr_q <= rrPtr_d;
      grant_q <= grant_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      write_q <= write_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready_o  = readyVec;
  assign bus.fifo_write_o = write_q;
  assign bus.fifo_data_o  = data_q;
  assign bus.occupancy_o  = occ_q;
  assign bus.full_o       = full_q;
  assign bus.grant_o      = grant_q;

endmodule

// File: tb/tb_nfifo_wr_arbiter.sv
// Directed bench for nfifo_wr_arbiter: every step drives inputs on the falling
// edge, states the ready pattern it requires, and pushes the beat it expects to
// see written one cycle later onto a scoreboard queue.
module tb_nfifo_wr_arbiter;

  logic clk;
  logic rstn;

  nfifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8)) bus ();

  nfifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic       expWrite;
  int         occModel;
  logic [9:0] sbq[$];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Outputs registered at the last rising edge: write strobe, beat, grant, occupancy.
  task automatic checkOutput(input string tag);
    logic [9:0] e;
    chk(32'(bus.fifo_write_o), 32'(expWrite), {tag, ".write"});
    if (expWrite) begin
      e = sbq.pop_front();
      chk(32'(bus.fifo_data_o), 32'(e[7:0]), {tag, ".data"});
      chk(32'(bus.grant_o), 32'(e[9:8]), {tag, ".grant"});
    end
    chk(32'(bus.occupancy_o), 32'(occModel), {tag, ".occ"});
    chk(32'(bus.full_o), 32'(occModel == 8), {tag, ".full"});
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [31:0] dv,
                               input logic rd, input logic emp, input logic [3:0] expReady,
                               input string tag);
    logic inc;
    logic dc;
    @(negedge clk);
    checkOutput(tag);
    rstn             = 1'b1;
    bus.req_valid_i  = v;
    bus.req_last_i   = l;
    bus.req_data_i   = dv;
    bus.fifo_read_i  = rd;
    bus.fifo_empty_i = emp;
    #1;
    chk(32'(bus.req_ready_o), 32'(expReady), {tag, ".ready"});
    inc = (expReady & v) != 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (expReady[i]) sbq.push_back({2'(i), dv[i*8 +: 8]});
    end
    expWrite = inc;
    dc       = rd && !emp && (occModel > 0);
    occModel = occModel + int'(inc) - int'(dc);
  endtask

  task automatic doReset(input int n, input logic [3:0] v, input bit checkFirst);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0 && checkFirst) checkOutput("preReset");
      if (k > 0) begin
        chk(32'(bus.fifo_write_o), 32'd0, "reset.write");
        chk(32'(bus.occupancy_o), 32'd0, "reset.occ");
      end
      rstn            = 1'b0;
      bus.req_valid_i = v;
      bus.req_last_i  = 4'hF;
      bus.fifo_read_i = 1'b0;
      #1;
      chk(32'(bus.req_ready_o), 32'd0, "reset.ready");
    end
    sbq.delete();
    expWrite = 1'b0;
    occModel = 0;
  endtask

  // Directed sequence: reset, round-robin fill, full/drain, spurious reads, lock, mid-packet reset.
  initial begin
    rstn             = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_last_i   = '0;
    bus.req_data_i   = '0;
    bus.fifo_read_i  = 1'b0;
    bus.fifo_empty_i = 1'b1;
    expWrite         = 1'b0;
    occModel         = 0;

    doReset(3, 4'hF, 1'b0);

    for (int r = 0; r < 2; r++) begin
      applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b0001, "rr0");
      applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b0010, "rr1");
      applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b0100, "rr2");
      applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b1000, "rr3");
    end
    applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b0000, "full");

    applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'b0000, "readNoBypass");
    applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'b0001, "acceptAndRead");
    applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b0010, "refill");
    applyStimulus(4'hF, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'b0000, "fullAgain");

    for (int d = 0; d < 9; d++)
      applyStimulus(4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'b0000, "drain");
    applyStimulus(4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4'b0000, "spuriousEmpty");

    applyStimulus(4'b1100, 4'b1000, 32'hB3A00000, 1'b0, 1'b0, 4'b0100, "lockBeat0");
    applyStimulus(4'b1100, 4'b1000, 32'hB3A10000, 1'b0, 1'b0, 4'b0100, "lockBeat1");
    applyStimulus(4'b1000, 4'b1000, 32'hB3A10000, 1'b0, 1'b0, 4'b0000, "lockGap0");
    applyStimulus(4'b1000, 4'b1000, 32'hB3A10000, 1'b0, 1'b0, 4'b0000, "lockGap1");
    applyStimulus(4'b1100, 4'b1100, 32'hB3A20000, 1'b0, 1'b0, 4'b0100, "lockLast");
    applyStimulus(4'b1000, 4'b1000, 32'hB3A20000, 1'b0, 1'b0, 4'b1000, "afterLock");

    applyStimulus(4'b0010, 4'b0000, 32'h0000C100, 1'b0, 1'b0, 4'b0010, "midLock");
    doReset(1, 4'b0011, 1'b1);
    applyStimulus(4'b0011, 4'b0011, 32'h0000C1C0, 1'b0, 1'b0, 4'b0001, "postReset");
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0, 4'b0000, "idle");

    @(negedge clk);
    checkOutput("end");
    chk(32'(sbq.size()), 32'd0, "sbqEmpty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nfifo_wr_arbiter.md
Name: nfifo_wr_arbiter

Overview:
- Shares one nfifo_inf write port between NUM_REQ requesters. Sits in the router input stage, in front of the shared FIFO.
- Arbitration is round-robin with packet locking: once a requester wins, it keeps the grant until it sends its last beat.
- Tracks FIFO occupancy internally (the FIFO exports only empty) and back-pressures requesters so the FIFO never overflows.
- Drives the FIFO write side through a registered output stage.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 8, data width; must match the nfifo_inf width
- DEPTH, 8, FIFO capacity in entries; sets the occupancy limit
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  synchronous reset, active-low
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_data_i  in  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_last_i  in  NUM_REQ  beat is the last beat of its packet
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
- fifo_write_o  out  1  to nfifo_inf write_i
- fifo_data_o  out  WIDTH  to nfifo_inf data_i
- fifo_read_i  in  1  copy of the nfifo_inf read_i strobe
- fifo_empty_i  in  1  from nfifo_inf empty_o
- occupancy_o  out  CNT_W  entries reserved or held in the FIFO
- full_o  out  1  occupancy_o == DEPTH
- grant_o  out  $clog2(NUM_REQ)  index of the current or last owner

Behaviour:
- Reset (rstn_i low at a clock edge) sets:
  - state = IDLE
  - occupancy = 0
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority
  - fifo_write_o = 0, fifo_data_o = 0, grant_o = 0
  - req_ready_o is all zeros while rstn_i is low.
- Reset mid-packet abandons the lock. Any beat registered but not yet written is dropped, because fifo_write_o is cleared.
- space = (occupancy < DEPTH). There is no same-cycle bypass from fifo_read_i.
- IDLE state:
  - Winner = first i with req_valid_i[i], searching from rr_ptr+1 upward with wrap modulo NUM_REQ.
  - req_ready_o[winner] = space; all other ready bits are 0.
  - Ready is combinational from req_valid_i, state and occupancy.
- Accept = req_valid_i[i] && req_ready_o[i]. On accept:
  - fifo_data_o <= beat data and fifo_write_o <= 1 at the next edge, giving exactly 1 cycle of latency.
  - grant_o <= i.
  - If req_last_i = 0: state <= LOCKED with owner = i.
  - If req_last_i = 1: stay in IDLE and set rr_ptr <= i.
- LOCKED state:
  - Only the owner is considered: req_ready_o[owner] = space; the owner's valid may drop between beats.
  - Other requesters get no ready, even when the owner is idle.
  - Accepting the owner's last beat sets state <= IDLE and rr_ptr <= owner.
- A cycle with no accept sets fifo_write_o <= 0; fifo_data_o holds its value.
- Occupancy update:
  - inc = accept this cycle; dec = fifo_read_i && !fifo_empty_i.
  - occupancy += inc - dec, so inc and dec together leave it unchanged.
  - Occupancy counts on accept, not on the FIFO write, so the in-flight registered beat is reserved.
  - dec while occupancy == 0 is ignored, with no underflow. This occurs only on an integration error.
- full_o and occupancy_o are registered copies of the counter.
- When full, no ready is asserted until a read frees an entry. The freed entry shows as ready in the cycle after the read edge.
- A requester must hold its valid and data stable until ready. The arbiter does not check this.

Test Plan:
- Reset: hold rstn_i=0 for 3 cycles while all valid are 1 → req_ready_o=0, fifo_write_o=0, occupancy_o=0. After release, first grant goes to requester 0.
- Round-robin with single-beat packets: all 4 requesters assert valid with last=1 and data = 0x10+i; no reads → writes appear as 0x10, 0x11, 0x12, 0x13, 0x10, … one per cycle, each 1 cycle after its accept. occupancy_o reaches 8, full_o=1, and ready goes to 0 after the 8th accept.
- Packet lock: requester 2 sends 3 beats (0xA0, 0xA1, 0xA2, last on the third) with a 2-cycle valid gap after beat 1, while requester 3 is valid throughout → no beat from requester 3 until 0xA2 is accepted. Requester 3 is granted on the next cycle.
- Full/drain: fill to 8, then pulse fifo_read_i for 1 cycle with empty=0 → occupancy_o=7 and ready re-asserts on the next cycle. A simultaneous accept and read at occupancy 7 holds it at 7.
- Spurious read: occupancy 0, fifo_read_i=1, fifo_empty_i=1 → occupancy stays 0. With fifo_empty_i=0 it also stays 0 (saturating).
- Reset mid-packet: requester 1 locked after 1 of 3 beats, then rstn_i=0 for 1 cycle → state is IDLE, occupancy is 0, and requester 0 wins the next arbitration.
